task_dispatch_queue: RTL and testbench

TASK_DISPATCH_QUEUE -- requirements
Module: task_dispatch_queue

---
 rtl/task_dispatch_queue.sv | 91 +++++++++
 tb/tb_task_dispatch_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/task_dispatch_queue.sv
// task_dispatch_queue: circular task FIFO dispatching to two cores with busy timers; DISPATCH_STATS_EN adds cnt_a/cnt_b
module task_dispatch_queue #(
  parameter int DEPTH = 8,
  parameter int TW = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [TW-1:0]           push_task,
  output logic                    task_ready,
  output logic [TW-1:0]           head_task,
  input  logic                    assign_to_a,
  input  logic                    assign_to_b,
  output logic                    core_a_busy,
  output logic                    core_b_busy,
  output logic                    disp_a_valid,
  output logic                    disp_b_valid,
  output logic [TW-5:0]           disp_id,
`ifdef DISPATCH_STATS_EN
  output logic [15:0]             cnt_a,
  output logic [15:0]             cnt_b,
`endif
  output logic [$clog2(DEPTH):0]  level
);
  localparam int AW = $clog2(DEPTH);
  logic [TW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [AW:0] level_next;
  logic [3:0] ctr_a, ctr_b, ctr_a_next, ctr_b_next, dur;
  logic push, pop, pop_a, pop_b;
  logic [TW-1:0] head_next;
  always_comb begin
    push = push_valid && push_ready;
    pop_a = task_ready && assign_to_a && !core_a_busy;
    pop_b = task_ready && assign_to_b && !core_b_busy && !pop_a;
    pop = pop_a || pop_b;
    dur = head_task[3:0] == 4'd0 ? 4'd1 : head_task[3:0];
    rd_next = rd_ptr + AW'(pop);
    level_next = level + (AW+1)'(push) - (AW+1)'(pop);
    head_next = level_next == '0 ? head_task :
                (level == (AW+1)'(pop) && push) ? push_task : mem[rd_next];
    ctr_a_next = pop_a ? dur : ctr_a - 4'(ctr_a != 4'd0);
    ctr_b_next = pop_b ? dur : ctr_b - 4'(ctr_b != 4'd0);
  end
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= push_task;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      push_ready <= 1'b0;
      task_ready <= 1'b0;
      head_task <= '0;
      ctr_a <= 4'd0;
      ctr_b <= 4'd0;
      core_a_busy <= 1'b0;
      core_b_busy <= 1'b0;
      disp_a_valid <= 1'b0;
      disp_b_valid <= 1'b0;
      disp_id <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_next;
      level <= level_next;
      push_ready <= level_next != (AW+1)'(DEPTH);
      task_ready <= level_next != '0;
      head_task <= head_next;
      ctr_a <= ctr_a_next;
      ctr_b <= ctr_b_next;
      core_a_busy <= ctr_a_next != 4'd0;
      core_b_busy <= ctr_b_next != 4'd0;
      disp_a_valid <= pop_a;
      disp_b_valid <= pop_b;
      if (pop) disp_id <= head_task[TW-1:4];
    end
  end
`ifdef DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a <= 16'd0;
      cnt_b <= 16'd0;
    end else begin
      cnt_a <= cnt_a + 16'(pop_a && cnt_a != 16'hffff);
      cnt_b <= cnt_b + 16'(pop_b && cnt_b != 16'hffff);
    end
  end
`endif
endmodule

// File: tb/tb_task_dispatch_queue.sv
// tb_task_dispatch_queue: scoreboard bench for task_dispatch_queue
module tb_task_dispatch_queue;
  logic clk = 1'b0, rst = 1'b1, push_valid = 1'b0, assign_to_a = 1'b0, assign_to_b = 1'b0;
  logic push_ready, task_ready, core_a_busy, core_b_busy, disp_a_valid, disp_b_valid;
  logic [7:0] push_task = 8'h00, head_task;
  logic [3:0] disp_id, level;
`ifdef DISPATCH_STATS_EN
  logic [15:0] cnt_a, cnt_b;
`endif
  int tests = 0, fails = 0;
  logic [7:0] model_q[$];
  logic [4:0] exp_q[$];
  always #5 clk = ~clk;
  task_dispatch_queue #(.DEPTH(8), .TW(8)) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_ready(push_ready),
    .push_task(push_task), .task_ready(task_ready), .head_task(head_task),
    .assign_to_a(assign_to_a), .assign_to_b(assign_to_b),
    .core_a_busy(core_a_busy), .core_b_busy(core_b_busy),
    .disp_a_valid(disp_a_valid), .disp_b_valid(disp_b_valid), .disp_id(disp_id),
`ifdef DISPATCH_STATS_EN
    .cnt_a(cnt_a), .cnt_b(cnt_b),
`endif
    .level(level)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(logic pv, logic [7:0] pt, logic ga, logic gb);
    push_valid = pv;
    push_task = pt;
    assign_to_a = ga;
    assign_to_b = gb;
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    assign_to_a = 1'b0;
    assign_to_b = 1'b0;
  endtask
  task automatic push_t(logic [7:0] w);
    step(1'b1, w, 1'b0, 1'b0);
    model_q.push_back(w);
  endtask
  task automatic grant(logic core, logic both = 1'b0, logic pv = 1'b0, logic [7:0] pt = 8'h00, logic acc = 1'b0);
    logic [7:0] w;
    step(pv, pt, !core || both, core || both);
    w = model_q.pop_front();
    exp_q.push_back({core, w[7:4]});
    if (acc) model_q.push_back(pt);
  endtask
  task automatic busy_len(logic core, output int n);
    n = 0;
    while ((core ? core_b_busy : core_a_busy) && n < 20) begin
      n++;
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask
  always @(negedge clk) begin
    logic [4:0] e;
    if (disp_a_valid || disp_b_valid) begin
      if (exp_q.size() == 0) check("unexpected_disp", {disp_a_valid, disp_b_valid}, 0);
      else begin
        e = exp_q.pop_front();
        check("disp", {disp_a_valid, disp_b_valid, disp_id}, {!e[4], e[4], e[3:0]});
      end
    end
  end
  initial begin
    int n;
    logic c;
    push_valid = 1'b1;
    push_task = 8'hAA;
    assign_to_a = 1'b1;
    assign_to_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", level, 0);
    check("rst_push_ready", push_ready, 0);
    check("rst_task_ready", task_ready, 0);
    check("rst_busy", {core_a_busy, core_b_busy}, 0);
    check("rst_disp", {disp_a_valid, disp_b_valid, disp_id}, 0);
    push_valid = 1'b0;
    assign_to_a = 1'b0;
    assign_to_b = 1'b0;
    rst = 1'b0;
    check("pr_before_edge", push_ready, 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("pr_after_rst", push_ready, 1);
    check("tr_after_rst", task_ready, 0);
    push_t(8'h13);
    check("push13_tr", task_ready, 1);
    check("push13_head", head_task, 8'h13);
    check("push13_level", level, 1);
    grant(1'b0);
    check("g13_busy", core_a_busy, 1);
    check("g13_level", level, 0);
    push_t(8'h25);
    check("a_busy_c2", core_a_busy, 1);
    check("push25_level", level, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("a_busy_c3", core_a_busy, 1);
    check("ignored_grant_level", level, 1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("a_idle_c4", core_a_busy, 0);
    grant(1'b1);
    busy_len(1'b1, n);
    check("b_busy_len5", n, 5);
    check("a_stays_idle", core_a_busy, 0);
    push_t(8'h30);
    grant(1'b0);
    busy_len(1'b0, n);
    check("a_busy_len_d0", n, 1);
    push_t(8'h41);
    push_t(8'h52);
    grant(1'b0, 1'b1);
    check("both_a_wins_level", level, 1);
    check("both_busy", {core_a_busy, core_b_busy}, 2'b10);
    grant(1'b1, 1'b1);
    check("both_b_takes_level", level, 0);
    check("both_busy2", {core_a_busy, core_b_busy}, 2'b01);
    busy_len(1'b1, n);
    check("b_busy_len2", n, 2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("empty_grant_level", level, 0);
    check("empty_head_hold", head_task, 8'h52);
    check("empty_tr", task_ready, 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) push_t(8'((i + 8) * 16));
    check("full_level", level, 8);
    check("full_pr", push_ready, 0);
    check("full_head", head_task, 8'h80);
    grant(1'b0, 1'b0, 1'b1, 8'hEE, 1'b0);
    check("full_pop_level", level, 7);
    check("full_pop_pr", push_ready, 1);
    check("full_pop_head", head_task, 8'h90);
    c = 1'b1;
    for (int i = 0; i < 10; i++) begin
      grant(c, 1'b0, 1'b1, 8'((i + 1) * 16), 1'b1);
      check("mixed_level", level, 7);
      c = !c;
    end
    n = model_q.size();
    for (int i = 0; i < n; i++) begin
      grant(c);
      c = !c;
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("drain_level", level, 0);
    check("drain_tr", task_ready, 0);
    check("drain_exp_empty", exp_q.size(), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    push_t(8'h7F);
    grant(1'b0);
    push_t(8'h11);
    push_t(8'h22);
    push_t(8'h33);
    check("pre_rst_level", level, 3);
    check("pre_rst_busy", core_a_busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_level", level, 0);
    check("mid_rst_tr", task_ready, 0);
    check("mid_rst_busy", core_a_busy, 0);
`ifdef DISPATCH_STATS_EN
    check("mid_rst_cnt_a", cnt_a, 0);
`endif
    rst = 1'b0;
    model_q.delete();
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("post_rst_pr", push_ready, 1);
    check("post_rst_busy", core_a_busy, 0);
    push_t(8'h44);
    check("post_rst_head", head_task, 8'h44);
    check("post_rst_level", level, 1);
    grant(1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("final_exp_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
